// File: rtl/mouse_pkg.sv
// Shared state encoding, PS/2 command constants and the init command table
// for the mouse host controller.
package mouse_pkg;

    typedef enum logic [6:0] {
        ST_POWERUP  = 7'b000_0001,
        ST_SEND     = 7'b000_0010,
        ST_WAIT_ACK = 7'b000_0100,
        ST_WAIT_BAT = 7'b000_1000,
        ST_WAIT_ID  = 7'b001_0000,
        ST_STREAM   = 7'b010_0000,
        ST_FAIL     = 7'b100_0000
    } state_e;

    localparam logic [7:0] PS2_RESET    = 8'hFF;
    localparam logic [7:0] PS2_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_SET_RATE = 8'hF3;
    localparam logic [7:0] PS2_GET_ID   = 8'hF2;
    localparam logic [7:0] PS2_SET_RES  = 8'hE8;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;

    localparam logic [3:0] IDX_RESET  = 4'd0;
    localparam logic [3:0] IDX_WHEEL  = 4'd1;
    localparam logic [3:0] IDX_GET_ID = 4'd7;
    localparam logic [3:0] IDX_RATE   = 4'd8;
    localparam logic [3:0] IDX_ENABLE = 4'd12;

    // Entries 1..6 are the IntelliMouse unlock knock (rates 200, 100, 80).
    function automatic logic [7:0] cmd_byte(input logic [3:0] idx,
                                            input logic [7:0] rate,
                                            input logic [7:0] res);
        logic [7:0] b;
        case (idx)
            4'd0:                   b = PS2_RESET;
            4'd1, 4'd3, 4'd5, 4'd8: b = PS2_SET_RATE;
            4'd2:                   b = 8'hC8;
            4'd4:                   b = 8'h64;
            4'd6:                   b = 8'h50;
            4'd7:                   b = PS2_GET_ID;
            4'd9:                   b = rate;
            4'd10:                  b = PS2_SET_RES;
            4'd11:                  b = res;
            4'd12:                  b = PS2_ENABLE;
            default:                b = PS2_RESET;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mouse_pkt_assembler.sv
// Collects stream bytes into a shadow buffer (re-syncing on status bit 3) and
// publishes complete 3- or 4-byte packets atomically with an interrupt flag.
module mouse_pkt_assembler (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_pkt4,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte,
    input  logic       i_expired,
    input  logic       i_int_ack,
    output logic       o_accept,
    output logic [7:0] o_status,
    output logic [7:0] o_dx,
    output logic [7:0] o_dy,
    output logic [7:0] o_dz,
    output logic       o_int
);
    logic [1:0] r_cnt;
    logic [7:0] r_sh0, r_sh1, r_sh2;
    logic       w_accept, w_last, w_done;

    // Byte acceptance: the first byte of a packet must carry the always-one bit 3.
    always_comb begin
        w_accept = 1'b0;
        if (i_en && i_byte_valid) begin
            w_accept = (r_cnt == 2'd0) ? i_byte[3] : 1'b1;
        end else begin
            w_accept = 1'b0;
        end
        w_last = i_pkt4 ? (r_cnt == 2'd3) : (r_cnt == 2'd2);
        w_done = w_accept && w_last;
    end

    assign o_accept = w_accept;

    // Byte counter and shadow buffer; a stale partial packet is simply dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 2'd0;
            r_sh0 <= 8'h00;
            r_sh1 <= 8'h00;
            r_sh2 <= 8'h00;
        end else if (!i_en || w_done) begin
            r_cnt <= 2'd0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
                2'd0:    r_sh0 <= i_byte;
                2'd1:    r_sh1 <= i_byte;
                2'd2:    r_sh2 <= i_byte;
                default: r_sh2 <= r_sh2;
            endcase
        end else if (i_expired) begin
            r_cnt <= 2'd0;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Published packet and interrupt flag; a completing packet beats an ACK.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_status <= 8'h00;
            o_dx     <= 8'h00;
            o_dy     <= 8'h00;
            o_dz     <= 8'h00;
            o_int    <= 1'b0;
        end else begin
            if (w_done) begin
                o_status <= r_sh0;
                o_dx     <= r_sh1;
                o_dy     <= i_pkt4 ? r_sh2 : i_byte;
                o_dz     <= i_pkt4 ? i_byte : 8'h00;
            end
            if (w_done) begin
                o_int <= 1'b1;
            end else if (i_int_ack) begin
                o_int <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mouse_master_ext.sv
// PS/2 mouse host controller: table-driven init with wheel detection and
// bounded retry, then streams packets through mouse_pkt_assembler.
module mouse_master_ext #(
    parameter int         POWERUP_CYCLES  = 500_000,
    parameter int         TIMEOUT_CYCLES  = 500_000,
    parameter int         SELFTEST_CYCLES = 25_000_000,
    parameter bit         WHEEL_EN        = 1'b1,
    parameter logic [7:0] SAMPLE_RATE     = 8'd100,
    parameter logic [7:0] RESOLUTION      = 8'h03,
    parameter int         MAX_RETRY       = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic [7:0] MOUSE_DZ,
    output logic [7:0] MOUSE_ID,
    output logic       SEND_INTERRUPT,
    input  logic       INTERRUPT_ACK,
    output logic       INIT_FAIL,
    output logic [6:0] current_state
);
    import mouse_pkg::*;

    localparam int T_MAX_A = (POWERUP_CYCLES > TIMEOUT_CYCLES) ? POWERUP_CYCLES : TIMEOUT_CYCLES;
    localparam int T_MAX   = (T_MAX_A > SELFTEST_CYCLES) ? T_MAX_A : SELFTEST_CYCLES;
    localparam int TW      = $clog2(T_MAX) + 1;
    localparam logic [TW-1:0] T_POWERUP  = TW'(POWERUP_CYCLES);
    localparam logic [TW-1:0] T_TIMEOUT  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_SELFTEST = TW'(SELFTEST_CYCLES);

    state_e        r_state, w_next_state;
    logic [3:0]    r_cmd_idx, w_next_idx;
    logic [7:0]    r_retry_cnt, w_next_retry, w_retry_base;
    logic [TW-1:0] r_timer, w_timer_load;
    logic [7:0]    r_mouse_id;
    logic          r_pkt4, r_send_pend, r_send_byte, r_read_enable, r_init_fail;
    logic [7:0]    r_byte_to_send;
    logic          w_expired, w_byte_ok, w_move, w_retry, w_clr_retry, w_latch_id;
    logic          w_reload, w_in_stream, w_accept;

    assign w_expired   = (r_timer == {TW{1'b0}});
    assign w_byte_ok   = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    assign w_in_stream = (r_state == ST_STREAM);

    // Next-state, command index and retry bookkeeping.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_cmd_idx;
        w_next_retry = r_retry_cnt;
        w_move       = 1'b0;
        w_retry      = 1'b0;
        w_clr_retry  = 1'b0;
        w_latch_id   = 1'b0;
        case (r_state)
            ST_POWERUP: begin
                if (w_expired) begin
                    w_next_state = ST_SEND;
                    w_next_idx   = IDX_RESET;
                    w_move       = 1'b1;
                end else begin
                    w_move = 1'b0;
                end
            end
            ST_SEND: begin
                if (BYTE_SENT) begin
                    w_next_state = ST_WAIT_ACK;
                    w_move       = 1'b1;
                end else begin
                    w_retry = w_expired;
                end
            end
            ST_WAIT_ACK: begin
                if (BYTE_READY) begin
                    if (!w_byte_ok || BYTE_READ == PS2_RESEND || BYTE_READ != PS2_ACK) begin
                        w_retry = 1'b1;
                    end else if (r_cmd_idx == IDX_RESET) begin
                        w_next_state = ST_WAIT_BAT;
                        w_move       = 1'b1;
                    end else if (r_cmd_idx == IDX_GET_ID) begin
                        w_next_state = ST_WAIT_ID;
                        w_move       = 1'b1;
                    end else if (r_cmd_idx == IDX_ENABLE) begin
                        w_next_state = ST_STREAM;
                        w_move       = 1'b1;
                    end else begin
                        w_next_state = ST_SEND;
                        w_next_idx   = r_cmd_idx + 4'd1;
                        w_move       = 1'b1;
                    end
                end else begin
                    w_retry = w_expired;
                end
            end
            ST_WAIT_BAT: begin
                if (BYTE_READY) begin
                    if (w_byte_ok && BYTE_READ == PS2_BAT_OK) begin
                        w_next_state = ST_WAIT_ID;
                        w_move       = 1'b1;
                    end else begin
                        w_retry = 1'b1;
                    end
                end else begin
                    w_retry = w_expired;
                end
            end
            ST_WAIT_ID: begin
                if (BYTE_READY) begin
                    if (!w_byte_ok) begin
                        w_retry = 1'b1;
                    end else if (r_cmd_idx == IDX_GET_ID) begin
                        w_latch_id   = 1'b1;
                        w_next_state = ST_SEND;
                        w_next_idx   = IDX_RATE;
                        w_move       = 1'b1;
                    end else if (BYTE_READ == 8'h00) begin
                        w_next_state = ST_SEND;
                        w_next_idx   = WHEEL_EN ? IDX_WHEEL : IDX_RATE;
                        w_move       = 1'b1;
                    end else begin
                        w_retry = 1'b1;
                    end
                end else begin
                    w_retry = w_expired;
                end
            end
            ST_STREAM: begin
                if (BYTE_READY && !w_byte_ok) begin
                    w_clr_retry = 1'b1;
                    w_retry     = 1'b1;
                end else begin
                    w_retry = 1'b0;
                end
            end
            ST_FAIL: begin
                w_next_state = ST_FAIL;
            end
            default: begin
                w_next_state = ST_POWERUP;
                w_move       = 1'b1;
            end
        endcase

        w_retry_base = w_clr_retry ? 8'h00 : r_retry_cnt;
        if (w_retry) begin
            if ((int'(w_retry_base) + 1) >= MAX_RETRY) begin
                w_next_state = ST_FAIL;
            end else begin
                w_next_state = ST_SEND;
                w_next_idx   = IDX_RESET;
                w_next_retry = w_retry_base + 8'd1;
            end
        end else begin
            w_next_retry = r_retry_cnt;
        end

        w_reload = w_move || w_retry || (w_in_stream && w_accept);
    end

    // Timer reload value depends on the state being entered.
    always_comb begin
        w_timer_load = T_TIMEOUT;
        case (w_next_state)
            ST_POWERUP:  w_timer_load = T_POWERUP;
            ST_WAIT_BAT: w_timer_load = T_SELFTEST;
            default:     w_timer_load = T_TIMEOUT;
        endcase
    end

    // State, command index, retry count and device-ID latch.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_POWERUP;
            r_cmd_idx   <= 4'd0;
            r_retry_cnt <= 8'h00;
            r_mouse_id  <= 8'h00;
            r_pkt4      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cmd_idx   <= w_next_idx;
            r_retry_cnt <= w_next_retry;
            if (w_latch_id) begin
                r_mouse_id <= BYTE_READ;
                r_pkt4     <= (BYTE_READ == 8'h03);
            end
        end
    end

    // Shared down-counter for power-up, ack, self-test and inter-byte waits.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_timer <= T_POWERUP;
        end else if (w_reload) begin
            r_timer <= w_timer_load;
        end else if (!w_expired) begin
            r_timer <= r_timer - TW'(1);
        end
    end

    // Registered transmit handshake and status outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_send_pend    <= 1'b0;
            r_send_byte    <= 1'b0;
            r_byte_to_send <= PS2_RESET;
            r_read_enable  <= 1'b0;
            r_init_fail    <= 1'b0;
        end else begin
            r_send_pend   <= w_reload && (w_next_state == ST_SEND);
            r_send_byte   <= r_send_pend && (r_state == ST_SEND);
            r_read_enable <= !((w_next_state == ST_SEND) || (w_next_state == ST_FAIL));
            r_init_fail   <= r_init_fail || (w_next_state == ST_FAIL);
            if (r_send_pend) begin
                r_byte_to_send <= cmd_byte(r_cmd_idx, SAMPLE_RATE, RESOLUTION);
            end
        end
    end

    mouse_pkt_assembler u_asm (
        .i_clk        (CLK),
        .i_rst        (RESET),
        .i_en         (w_in_stream),
        .i_pkt4       (r_pkt4),
        .i_byte_valid (w_byte_ok),
        .i_byte       (BYTE_READ),
        .i_expired    (w_expired),
        .i_int_ack    (INTERRUPT_ACK),
        .o_accept     (w_accept),
        .o_status     (MOUSE_STATUS),
        .o_dx         (MOUSE_DX),
        .o_dy         (MOUSE_DY),
        .o_dz         (MOUSE_DZ),
        .o_int        (SEND_INTERRUPT)
    );

    assign SEND_BYTE     = r_send_byte;
    assign BYTE_TO_SEND  = r_byte_to_send;
    assign READ_ENABLE   = r_read_enable;
    assign MOUSE_ID      = r_mouse_id;
    assign INIT_FAIL     = r_init_fail;
    assign current_state = r_state;

endmodule

// File: tb/tb_mouse_master_ext.sv
// Directed bench: one instance without and one with wheel detection, driven by
// command/response and packet tables plus hand-written corner sequences.
module tb_mouse_master_ext;
    localparam int PU = 20;
    localparam int TO = 40;
    localparam int ST = 60;
    localparam int MR = 3;

    typedef struct {
        logic [7:0] cmd;
        int         nr;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
    } cmd_vec_t;

    typedef struct {
        int          d;
        int          n;
        logic [39:0] bs;
        logic [31:0] exp;
    } pkt_vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]      byte_sent, byte_ready, int_ack;
    logic [1:0][7:0] brx;
    logic [1:0][1:0] berr;
    wire  [1:0]      send_byte, read_en, intr, init_fail;
    wire  [1:0][7:0] btx, st, dx, dy, dz, id;
    wire  [1:0][6:0] cur;

    int checks = 0;
    int failures = 0;

    cmd_vec_t init0 [6];
    cmd_vec_t init1 [13];
    pkt_vec_t pkts  [5];

    mouse_master_ext #(.POWERUP_CYCLES(PU), .TIMEOUT_CYCLES(TO), .SELFTEST_CYCLES(ST),
                       .WHEEL_EN(1'b0), .SAMPLE_RATE(8'd100), .RESOLUTION(8'h03),
                       .MAX_RETRY(MR)) u_dut0 (
        .CLK(clk), .RESET(rst), .SEND_BYTE(send_byte[0]), .BYTE_TO_SEND(btx[0]),
        .BYTE_SENT(byte_sent[0]), .READ_ENABLE(read_en[0]), .BYTE_READ(brx[0]),
        .BYTE_ERROR_CODE(berr[0]), .BYTE_READY(byte_ready[0]), .MOUSE_STATUS(st[0]),
        .MOUSE_DX(dx[0]), .MOUSE_DY(dy[0]), .MOUSE_DZ(dz[0]), .MOUSE_ID(id[0]),
        .SEND_INTERRUPT(intr[0]), .INTERRUPT_ACK(int_ack[0]), .INIT_FAIL(init_fail[0]),
        .current_state(cur[0]));

    mouse_master_ext #(.POWERUP_CYCLES(PU), .TIMEOUT_CYCLES(TO), .SELFTEST_CYCLES(ST),
                       .WHEEL_EN(1'b1), .SAMPLE_RATE(8'd40), .RESOLUTION(8'h02),
                       .MAX_RETRY(MR)) u_dut1 (
        .CLK(clk), .RESET(rst), .SEND_BYTE(send_byte[1]), .BYTE_TO_SEND(btx[1]),
        .BYTE_SENT(byte_sent[1]), .READ_ENABLE(read_en[1]), .BYTE_READ(brx[1]),
        .BYTE_ERROR_CODE(berr[1]), .BYTE_READY(byte_ready[1]), .MOUSE_STATUS(st[1]),
        .MOUSE_DX(dx[1]), .MOUSE_DY(dy[1]), .MOUSE_DZ(dz[1]), .MOUSE_ID(id[1]),
        .SEND_INTERRUPT(intr[1]), .INTERRUPT_ACK(int_ack[1]), .INIT_FAIL(init_fail[1]),
        .current_state(cur[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rx(input int d, input logic [7:0] b, input logic [1:0] e, input logic ack);
        @(posedge clk); #1;
        brx[d] = b; berr[d] = e; byte_ready[d] = 1'b1; int_ack[d] = ack;
        @(posedge clk); #1;
        byte_ready[d] = 1'b0; berr[d] = 2'b00; int_ack[d] = 1'b0;
    endtask

    task automatic ack_int(input int d);
        @(posedge clk); #1 int_ack[d] = 1'b1;
        @(posedge clk); #1 int_ack[d] = 1'b0;
        @(negedge clk);
        check("int_cleared", {31'd0, intr[d]}, 32'd0);
    endtask

    task automatic cmd_step(input int d, input cmd_vec_t v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (send_byte[d] !== 1'b1 && n < 100);
        check("send_byte_seen", {31'd0, send_byte[d]}, 32'd1);
        check("cmd_byte", {24'd0, btx[d]}, {24'd0, v.cmd});
        @(posedge clk); #1 byte_sent[d] = 1'b1;
        @(posedge clk); #1 byte_sent[d] = 1'b0;
        if (v.nr > 0) rx(d, v.r0, 2'b00, 1'b0);
        if (v.nr > 1) rx(d, v.r1, 2'b00, 1'b0);
        if (v.nr > 2) rx(d, v.r2, 2'b00, 1'b0);
    endtask

    task automatic run_pkt(input pkt_vec_t p);
        for (int k = 0; k < p.n; k++) begin
            if (k == p.n - 1) begin
                @(negedge clk);
                check("int_before_last", {31'd0, intr[p.d]}, 32'd0);
            end
            rx(p.d, p.bs[39-8*k -: 8], 2'b00, 1'b0);
        end
        @(negedge clk);
        check("packet", {st[p.d], dx[p.d], dy[p.d], dz[p.d]}, p.exp);
        check("int_set", {31'd0, intr[p.d]}, 32'd1);
        ack_int(p.d);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        init0[0] = '{8'hFF, 3, 8'hFA, 8'hAA, 8'h00};
        init0[1] = '{8'hF3, 1, 8'hFA, 8'h00, 8'h00};
        init0[2] = '{8'h64, 1, 8'hFA, 8'h00, 8'h00};
        init0[3] = '{8'hE8, 1, 8'hFA, 8'h00, 8'h00};
        init0[4] = '{8'h03, 1, 8'hFA, 8'h00, 8'h00};
        init0[5] = '{8'hF4, 1, 8'hFA, 8'h00, 8'h00};
        init1[0]  = '{8'hFF, 3, 8'hFA, 8'hAA, 8'h00};
        init1[1]  = '{8'hF3, 1, 8'hFA, 8'h00, 8'h00};
        init1[2]  = '{8'hC8, 1, 8'hFA, 8'h00, 8'h00};
        init1[3]  = '{8'hF3, 1, 8'hFA, 8'h00, 8'h00};
        init1[4]  = '{8'h64, 1, 8'hFA, 8'h00, 8'h00};
        init1[5]  = '{8'hF3, 1, 8'hFA, 8'h00, 8'h00};
        init1[6]  = '{8'h50, 1, 8'hFA, 8'h00, 8'h00};
        init1[7]  = '{8'hF2, 2, 8'hFA, 8'h03, 8'h00};
        init1[8]  = '{8'hF3, 1, 8'hFA, 8'h00, 8'h00};
        init1[9]  = '{8'h28, 1, 8'hFA, 8'h00, 8'h00};
        init1[10] = '{8'hE8, 1, 8'hFA, 8'h00, 8'h00};
        init1[11] = '{8'h02, 1, 8'hFA, 8'h00, 8'h00};
        init1[12] = '{8'hF4, 1, 8'hFA, 8'h00, 8'h00};
        pkts[0] = '{0, 3, 40'h08_01_02_00_00, 32'h08_01_02_00};
        pkts[1] = '{0, 4, 40'h00_09_02_03_00, 32'h09_02_03_00};
        pkts[2] = '{1, 4, 40'h08_05_FB_01_00, 32'h08_05_FB_01};
        pkts[3] = '{1, 5, 40'h00_0C_7F_80_FF, 32'h0C_7F_80_FF};
        pkts[4] = '{1, 4, 40'h18_F0_0F_02_00, 32'h18_F0_0F_02};

        rst = 1'b1;
        byte_sent = 2'b00; byte_ready = 2'b00; int_ack = 2'b00;
        brx = '0; berr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_state", {25'd0, cur[d]}, 32'h01);
            check("rst_byte_to_send", {24'd0, btx[d]}, 32'hFF);
            check("rst_flags", {28'd0, send_byte[d], read_en[d], intr[d], init_fail[d]}, 32'd0);
            check("rst_data", {st[d], dx[d], dy[d], dz[d]}, 32'd0);
            check("rst_id", {24'd0, id[d]}, 32'd0);
        end

        // Silent device: every attempt times out, then FAIL
        @(posedge clk); #1 rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (send_byte[0] === 1'b1) pulses++;
            if (init_fail[0] === 1'b1) break;
        end
        check("retry_attempts", pulses, MR);
        check("init_fail", {30'd0, init_fail}, 32'h3);
        check("fail_read_en", {31'd0, read_en[0]}, 32'd0);
        check("fail_state", {25'd0, cur[0]}, 32'h40);

        do_reset();
        for (int i = 0; i < 6; i++) cmd_step(0, init0[i]);
        @(negedge clk);
        check("nowheel_stream", {25'd0, cur[0]}, 32'h20);
        check("nowheel_id", {24'd0, id[0]}, 32'h00);
        run_pkt(pkts[0]);
        run_pkt(pkts[1]);

        do_reset();
        for (int i = 0; i < 13; i++) cmd_step(1, init1[i]);
        @(negedge clk);
        check("wheel_stream", {25'd0, cur[1]}, 32'h20);
        check("wheel_id", {24'd0, id[1]}, 32'h03);
        for (int i = 2; i < 5; i++) run_pkt(pkts[i]);

        // Inter-byte gap drops the partial packet
        rx(1, 8'h0A, 2'b00, 1'b0);
        rx(1, 8'h11, 2'b00, 1'b0);
        repeat (TO + 10) @(posedge clk);
        @(negedge clk);
        check("gap_outputs_held", {st[1], 7'd0, intr[1]}, 32'h1800);
        run_pkt('{1, 4, 40'h0B_21_22_23_00, 32'h0B_21_22_23});

        // ACK coinciding with completion
        rx(1, 8'h28, 2'b00, 1'b0);
        rx(1, 8'h31, 2'b00, 1'b0);
        rx(1, 8'h32, 2'b00, 1'b0);
        rx(1, 8'h33, 2'b00, 1'b1);
        @(negedge clk);
        check("ack_same_cycle_int", {31'd0, intr[1]}, 32'd1);
        check("ack_same_cycle_pkt", {st[1], dx[1], dy[1], dz[1]}, 32'h28_31_32_33);

        // Reset mid-packet
        rx(1, 8'h09, 2'b00, 1'b0);
        rx(1, 8'h01, 2'b00, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_state", {25'd0, cur[1]}, 32'h01);
        check("midrst_data", {st[1], dx[1], dy[1], dz[1]}, 32'd0);
        check("midrst_flags", {29'd0, intr[1], send_byte[1], read_en[1]}, 32'd0);
        check("midrst_byte_to_send", {24'd0, btx[1]}, 32'hFF);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 13; i++) cmd_step(1, init1[i]);
        @(negedge clk);
        check("reinit_stream", {25'd0, cur[1]}, 32'h20);

        // Receive error in STREAM falls back to re-init
        rx(1, 8'h08, 2'b10, 1'b0);
        @(negedge clk);
        check("stream_err_state", {25'd0, cur[1]}, 32'h02);
        check("stream_err_read_en", {31'd0, read_en[1]}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mouse_master_ext.md
# mouse_master_ext

Parametrised PS/2 mouse host controller, the successor of the basic reset/stream master. Sits between the PS/2 transmitter/receiver byte layer and the bus-side mouse register/interrupt interface. Adds a table-driven init sequence with optional IntelliMouse wheel detection, sample-rate and resolution programming, timeouts with bounded retry, packet re-sync, and atomic 3- or 4-byte packet output.

## Interface
- `POWERUP_CYCLES`, default 500_000: idle wait after reset before the first command.
- `TIMEOUT_CYCLES`, default 500_000: ack/transmit/inter-byte timeout.
- `SELFTEST_CYCLES`, default 25_000_000: max wait for the BAT byte after a reset command.
- `WHEEL_EN`, default 1: attempt the wheel-mode unlock sequence.
- `SAMPLE_RATE`, default 8'd100: argument sent with F3.
- `RESOLUTION`, default 8'h03: argument sent with E8.
- `MAX_RETRY`, default 3: failed init attempts before FAIL.
- `CLK  in  1`: single clock, rising edge.
- `RESET  in  1`: asynchronous, active-high reset.
- `SEND_BYTE  out  1`: one-cycle transmit request.
- `BYTE_TO_SEND  out  8`: command byte, stable from the SEND_BYTE pulse until BYTE_SENT.
- `BYTE_SENT  in  1`: transmitter done pulse.
- `READ_ENABLE  out  1`: receiver enable.
- `BYTE_READ  in  8`: received byte.
- `BYTE_ERROR_CODE  in  2`: non-zero means framing/parity error.
- `BYTE_READY  in  1`: one-cycle received-byte strobe.
- `MOUSE_STATUS`, `MOUSE_DX`, `MOUSE_DY`, `MOUSE_DZ`  out  8 each: last complete packet. DZ is 0 in 3-byte mode.
- `MOUSE_ID  out  8`: device ID read back (00 or 03).
- `SEND_INTERRUPT  out  1`: packet-available flag.
- `INTERRUPT_ACK  in  1`: clears SEND_INTERRUPT.
- `INIT_FAIL  out  1`: sticky; high once retries are exhausted.
- `current_state  out  7`: one-hot state, for debug.

## Operation
- **States** (one-hot): POWERUP, SEND, WAIT_ACK, WAIT_BAT, WAIT_ID, STREAM, FAIL.
- **Command table**, indexed by `cmd_idx`:
  - 0: FF
  - 1–6: F3 C8 F3 64 F3 50
  - 7: F2
  - 8: F3, 9: SAMPLE_RATE
  - 10: E8, 11: RESOLUTION
  - 12: F4
  - With WHEEL_EN=0, the index jumps 0→8.
- **POWERUP**: when the timer expires → SEND with `cmd_idx=0`.
- **SEND**:
  - Pulse SEND_BYTE on the first cycle.
  - BYTE_SENT → WAIT_ACK.
  - Timeout → retry.
- **WAIT_ACK**, on BYTE_READY:
  - Error code non-zero, or byte not FA → retry. A byte of FE is also a retry.
  - FA with idx 0 → WAIT_BAT.
  - FA with idx 7 → WAIT_ID.
  - FA with idx 12 → STREAM.
  - FA otherwise → idx+1, SEND.
  - Timeout → retry.
- **WAIT_BAT**: AA → WAIT_ID. Any other byte, an error, or SELFTEST_CYCLES expiry → retry.
- **WAIT_ID**:
  - After idx 0: expects 00, then goes to the next index (1, or 8 with WHEEL_EN=0) and SEND.
  - After idx 7: latches MOUSE_ID. Packet length is 4 if ID==03, otherwise 3. Then idx 8, SEND.
  - Error or timeout → retry.
- **Retry**:
  - Increments `retry_cnt` and restarts at SEND with idx 0.
  - If `retry_cnt` would reach MAX_RETRY → FAIL instead.
  - FAIL sets INIT_FAIL=1 and is left only by RESET.
- **STREAM**:
  - Byte 0 is accepted only if bit3=1; otherwise it is discarded (re-sync).
  - Bytes are collected into a shadow buffer.
  - On the last byte, the shadow buffer is copied to the output registers in a single cycle.
  - A gap longer than TIMEOUT_CYCLES mid-packet resets the byte counter. The partial packet is dropped and the outputs are unchanged.
  - BYTE_READY with an error → retry path, with `retry_cnt` cleared first.
- **READ_ENABLE** is 0 in SEND and FAIL, and 1 elsewhere.
- **SEND_INTERRUPT**:
  - Set on packet completion; cleared by INTERRUPT_ACK.
  - If completion and ACK occur in the same cycle, set wins.

## Timing
- **Reset values**:
  - All data outputs 0.
  - BYTE_TO_SEND = FF.
  - SEND_BYTE, READ_ENABLE, SEND_INTERRUPT, INIT_FAIL = 0.
  - `current_state` = POWERUP.
  - `retry_cnt` and `cmd_idx` = 0.
- **Reset mid-operation**: abandons everything immediately, including a pending transmit.
- **Output registering**: all outputs are registered. SEND_BYTE rises 1 cycle after SEND is entered. BYTE_TO_SEND is valid on that same edge.
- **Timer**: a single down-counter of width `$clog2(max of the three cycle params)+1`.
  - Reloaded on every state entry, and on every accepted byte in STREAM.
  - Expiry is the cycle it reads 0.
- **Packet latency**: output registers and SEND_INTERRUPT update on the edge after BYTE_READY of the final byte.
- **Simultaneous BYTE_READY and timer expiry**: BYTE_READY wins.

## Structure
- Package `mouse_pkg` holds:
  - the state one-hot localparams;
  - PS/2 command constants (FF, F4, F3, F2, E8, FA, FE, AA);
  - the command-table function `cmd_byte(idx, SAMPLE_RATE, RESOLUTION)`.
- Sub-module `mouse_pkt_assembler` holds the STREAM byte counter, re-sync, shadow buffer, output registers and interrupt flag. It is enabled by `state==STREAM` and takes the packet length as an input.

## Test plan
- WHEEL_EN=0 model responds FA, AA, 00, then FA to each of F3 64 E8 03 F4 → STREAM reached; 13 bytes total sent is not expected, only 6 commands; MOUSE_ID=00.
- WHEEL_EN=1 model returns ID 03, then the packet 08 05 FB 01 → STATUS=08, DX=05, DY=FB, DZ=01, SEND_INTERRUPT=1 on the next edge.
- STREAM receives 00 (bit3=0), then 09 02 03 → the 00 is discarded; the packet is 09/02/03.
- Model never answers FF → each attempt retries after TIMEOUT_CYCLES; INIT_FAIL=1 after MAX_RETRY; READ_ENABLE=0.
- INTERRUPT_ACK lands on the same cycle as a completing packet → SEND_INTERRUPT stays 1.
- RESET asserted mid-packet, then released → outputs 0, POWERUP entered, init re-runs.
